// File: rtl/iir_llki_pkg.sv
// Shared types and helpers for the keyed multi-channel IIR filter.
package iir_llki_pkg;

    localparam int KEY_WORD_W = 64;

    typedef enum logic [1:0] {
        KS_UNKEYED = 2'd0,
        KS_LOADING = 2'd1,
        KS_KEYED   = 2'd2
    } key_state_t;

    // Channels share the key slices round-robin when there are more channels than slices.
    function automatic int unsigned slice_index(input int unsigned ch, input int unsigned n_slices);
        return ch % n_slices;
    endfunction

endpackage

// File: rtl/llki_key_loader.sv
// Key-word loader: assembles the actual key from 64-bit words and tracks keyed state.
//
// state      | meaning
// -----------+-------------------------------------------------
// KS_UNKEYED | no key loaded (or cleared); samples use zero key
// KS_LOADING | partial key loaded, waiting for remaining words
// KS_KEYED   | full key loaded; a new word restarts loading
module llki_key_loader
    import iir_llki_pkg::*;
#(
    parameter int                              KEY_WORDS = 2,
    parameter logic [KEY_WORD_W*KEY_WORDS-1:0] EXP_KEY   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    output logic                              key_ready,
    input  logic [KEY_WORD_W-1:0]             key_data,
    input  logic                              key_clear,
    output logic [KEY_WORD_W*KEY_WORDS-1:0]   key_q,
    output logic                              loading,
    output logic                              keyed,
    output logic                              key_match
);

    localparam int              CNT_W     = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(KEY_WORDS - 1);

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             key_accept;

    assign key_accept = key_valid & key_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= KS_UNKEYED;
        else      state_q <= state_d;
    end

    // Next-state logic; key_clear overrides any word arriving the same cycle
    always_comb begin
        state_d = state_q;
        if (key_clear) begin
            state_d = KS_UNKEYED;
        end else if (key_accept) begin
            case (state_q)
                KS_LOADING: state_d = (cnt_q == LAST_WORD) ? KS_KEYED : KS_LOADING;
                default:    state_d = (KEY_WORDS == 1) ? KS_KEYED : KS_LOADING;
            endcase
        end
    end

    // Key register and word counter; counter is 0 outside LOADING so a new load starts at word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
            cnt_q <= '0;
        end else if (key_clear) begin
            key_q <= '0;
            cnt_q <= '0;
        end else if (key_accept) begin
            key_q[cnt_q*KEY_WORD_W +: KEY_WORD_W] <= key_data;
            cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Outputs: loader always takes words; match is purely combinational on the key register
    always_comb begin
        key_ready = 1'b1;
        loading   = (state_q == KS_LOADING);
        keyed     = (state_q == KS_KEYED);
        key_match = (key_q == EXP_KEY);
    end

endmodule

// File: rtl/iir_filter_llki_mc.sv
// Keyed multi-channel first-order IIR: y += (x - y) >>> SHIFT per channel,
// with the input unmasked by expected-key ^ actual-key slices. Two-stage pipeline.
module iir_filter_llki_mc
    import iir_llki_pkg::*;
#(
    parameter int                              N_CH      = 4,
    parameter int                              DATA_W    = 32,
    parameter int                              KEY_WORDS = 2,
    parameter int                              SHIFT     = 2,
    parameter logic [KEY_WORD_W*KEY_WORDS-1:0] EXP_KEY   = '0,
    localparam int                             CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [KEY_WORD_W-1:0] key_data,
    input  logic                  key_clear,
    input  logic                  ch_clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [DATA_W-1:0]     out_data,
    output logic                  keyed,
    output logic                  key_match
);

    localparam int KEY_W = KEY_WORD_W * KEY_WORDS;
    localparam int N_SL  = KEY_W / DATA_W;

    logic [KEY_W-1:0]  key_q;
    logic              key_loading;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [DATA_W-1:0] s1_data;
    logic [DATA_W-1:0] y_q [N_CH];

    logic              out_adv, s1_free, in_accept;
    int unsigned       sl;
    logic [DATA_W-1:0] masked;
    logic [DATA_W-1:0] y_cur, y_new;
    logic signed [DATA_W:0] diff, step;

    llki_key_loader #(
        .KEY_WORDS (KEY_WORDS),
        .EXP_KEY   (EXP_KEY)
    ) u_key_loader (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_data  (key_data),
        .key_clear (key_clear),
        .key_q     (key_q),
        .loading   (key_loading),
        .keyed     (keyed),
        .key_match (key_match)
    );

    assign out_adv   = !out_valid || out_ready;
    assign s1_free   = !s1_valid || out_adv;
    assign in_ready  = !key_loading && s1_free;
    assign in_accept = in_valid && in_ready;

    // Stage-1 unmasking: a matching key cancels the expected-key slice
    always_comb begin
        sl     = slice_index(32'(in_ch), N_SL);
        masked = in_data ^ EXP_KEY[sl*DATA_W +: DATA_W] ^ key_q[sl*DATA_W +: DATA_W];
    end

    // Stage-1 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_data  <= '0;
        end else if (s1_free) begin
            s1_valid <= in_accept;
            if (in_accept) begin
                s1_ch   <= in_ch;
                s1_data <= masked;
            end
        end
    end

    // Stage-2 filter step; difference kept one bit wider so it cannot overflow
    always_comb begin
        y_cur = y_q[s1_ch];
        diff  = {s1_data[DATA_W-1], s1_data} - {y_cur[DATA_W-1], y_cur};
        step  = diff >>> SHIFT;
        y_new = y_cur + step[DATA_W-1:0];
    end

    // Output register and channel state; ch_clear drops the same-edge state write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            for (int i = 0; i < N_CH; i++) y_q[i] <= '0;
        end else begin
            if (out_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ch   <= s1_ch;
                    out_data <= y_new;
                end
            end
            if (ch_clear) begin
                for (int i = 0; i < N_CH; i++) y_q[i] <= '0;
            end else if (out_adv && s1_valid) begin
                y_q[s1_ch] <= y_new;
            end
        end
    end

endmodule

// File: tb/tb_iir_filter_llki_mc.sv
// Bench for iir_filter_llki_mc: directed scenarios plus randomized traffic
// against an arithmetic reference model of the keyed IIR.
module tb_iir_filter_llki_mc;

    localparam int           N_CH      = 4;
    localparam int           DATA_W    = 32;
    localparam int           KEY_WORDS = 2;
    localparam int           SHIFT     = 2;
    localparam logic [127:0] EXP_KEY   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam int           SL_PER_WORD = 64 / DATA_W;
    localparam longint       DIV       = longint'(1) << SHIFT;

    logic        clk, rst;
    logic        key_valid, key_ready, key_clear, ch_clear;
    logic [63:0] key_data;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_ch, out_ch;
    logic [31:0] in_data, out_data;
    logic        keyed, key_match;

    iir_filter_llki_mc #(
        .N_CH(N_CH), .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .SHIFT(SHIFT), .EXP_KEY(EXP_KEY)
    ) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data), .key_clear(key_clear),
        .ch_clear(ch_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .keyed(keyed), .key_match(key_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
        int          acc;
    } item_t;

    int          n_checks, n_err, cyc;
    item_t       exp_q[$];
    logic [31:0] got_q[$];
    logic [63:0] exp_w [KEY_WORDS];
    logic [63:0] act_w [KEY_WORDS];
    logic [31:0] y_m [N_CH];
    int          widx, kst;
    bit          lat_chk, prev_stall;
    logic [31:0] prev_d;
    logic [1:0]  prev_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: unmask with expected^actual key chunk, then y + floor((x - y) / 2^SHIFT), wrapped
    function automatic logic [31:0] model_out(input int ch, input logic [31:0] x);
        int          s    = ch % (KEY_WORDS * SL_PER_WORD);
        int          w    = s / SL_PER_WORD;
        int          h    = s % SL_PER_WORD;
        logic [63:0] m64  = exp_w[w] ^ act_w[w];
        logic [31:0] mask = (h == 0) ? m64[31:0] : m64[63:32];
        longint      xv   = longint'($signed(x ^ mask));
        longint      yv   = longint'($signed(y_m[ch]));
        longint      d    = xv - yv;
        longint      st   = (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);
        return 32'(yv + st);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < N_CH; i++) y_m[i] = '0;
        for (int i = 0; i < KEY_WORDS; i++) act_w[i] = '0;
        widx = 0;
        kst = 0;
        prev_stall = 0;
    endtask

    // One clock: inputs already set at the falling edge; observe, update model, advance
    task automatic step();
        item_t it;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(prev_d));
            chk("hold_ch", 64'(out_ch), 64'(prev_ch));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                it = exp_q.pop_front();
                chk("out_ch", 64'(out_ch), 64'(it.ch));
                chk("out_data", 64'(out_data), 64'(it.data));
                if (lat_chk) chk("latency", 64'(cyc - it.acc), 64'd2);
            end
            got_q.push_back(out_data);
        end
        if (in_valid && in_ready) begin
            it.ch   = in_ch;
            it.data = model_out(int'(in_ch), in_data);
            it.acc  = cyc;
            y_m[in_ch] = it.data;
            exp_q.push_back(it);
        end
        prev_stall = out_valid && !out_ready;
        prev_d  = out_data;
        prev_ch = out_ch;
        if (key_clear) begin
            for (int i = 0; i < KEY_WORDS; i++) act_w[i] = '0;
            widx = 0;
            kst  = 0;
        end else if (key_valid) begin
            act_w[widx] = key_data;
            if (widx == KEY_WORDS - 1) begin
                widx = 0;
                kst  = 2;
            end else begin
                widx = widx + 1;
                kst  = 1;
            end
        end
        if (ch_clear) for (int i = 0; i < N_CH; i++) y_m[i] = '0;
        @(negedge clk);
        cyc++;
        chk("keyed", 64'(keyed), 64'(kst == 2));
        chk("key_match", 64'(key_match), 64'({act_w[1], act_w[0]} == EXP_KEY));
    endtask

    task automatic idle_inputs();
        in_valid  = 0;
        key_valid = 0;
        key_clear = 0;
        ch_clear  = 0;
        out_ready = 1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            idle_inputs();
            step();
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_key(input logic [63:0] w0, input logic [63:0] w1);
        key_valid = 1;
        key_data  = w0;
        step();
        chk("in_ready_loading", 64'(in_ready), 64'd0);
        key_data = w1;
        step();
        key_valid = 0;
    endtask

    task automatic send(input logic [1:0] ch, input logic [31:0] data);
        in_valid  = 1;
        in_ch     = ch;
        in_data   = data;
        out_ready = 1;
        #1 chk("in_ready_send", 64'(in_ready), 64'd1);
        step();
        in_valid = 0;
    endtask

    task automatic clear_y();
        ch_clear = 1;
        step();
        ch_clear = 0;
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [31:0] expv);
        if (idx < got_q.size()) chk(tag, 64'(got_q[idx]), 64'(expv));
        else chk({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    endtask

    initial begin
        int k;
        bit acc;
        clk = 0;
        rst = 0;
        n_checks = 0;
        n_err = 0;
        cyc = 0;
        lat_chk = 0;
        idle_inputs();
        key_data = '0;
        in_ch = '0;
        in_data = '0;
        exp_w[0] = EXP_KEY[63:0];
        exp_w[1] = EXP_KEY[127:64];
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_keyed", 64'(keyed), 64'd0);
        chk("rst_key_match", 64'(key_match), 64'd0);
        @(negedge clk);
        rst = 1;

        // Exact key, same-channel back-to-back
        load_key(exp_w[0], exp_w[1]);
        got_q.delete();
        lat_chk = 1;
        send(2'd0, 32'h100);
        send(2'd0, 32'h100);
        drain("t_exact");
        lat_chk = 0;
        chk_got("t_exact_o0", 0, 32'h40);
        chk_got("t_exact_o1", 1, 32'h70);
        chk("t_exact_keyed", 64'(keyed), 64'd1);
        chk("t_exact_match", 64'(key_match), 64'd1);

        // Key with one bit flipped in word 0 corrupts only channel 0
        load_key(exp_w[0] ^ 64'h100, exp_w[1]);
        clear_y();
        got_q.delete();
        send(2'd0, 32'h100);
        send(2'd1, 32'h100);
        drain("t_flip");
        chk_got("t_flip_ch0", 0, 32'h0);
        chk_got("t_flip_ch1", 1, 32'h40);
        chk("t_flip_match", 64'(key_match), 64'd0);

        // Interleaved channels at full rate
        load_key(exp_w[0], exp_w[1]);
        clear_y();
        got_q.delete();
        lat_chk = 1;
        send(2'd0, 32'h100);
        send(2'd1, 32'h200);
        send(2'd0, 32'h100);
        drain("t_ilv");
        lat_chk = 0;
        chk_got("t_ilv_o0", 0, 32'h40);
        chk_got("t_ilv_o1", 1, 32'h80);
        chk_got("t_ilv_o2", 2, 32'h70);

        // Back-pressure: out_ready low for 5 cycles during a 4-sample stream
        clear_y();
        got_q.delete();
        k = 0;
        for (int c = 0; c < 30 && (k < 4 || exp_q.size() > 0); c++) begin
            out_ready = (c >= 5);
            in_valid  = (k < 4);
            in_ch     = 2'(k);
            in_data   = 32'((k + 1) * 256);
            #1;
            if (c == 2) chk("t_bp_in_ready_low", 64'(in_ready), 64'd0);
            acc = in_valid && in_ready;
            step();
            if (acc) k++;
        end
        drain("t_bp");
        chk("t_bp_count", 64'(got_q.size()), 64'd4);
        chk_got("t_bp_o0", 0, 32'h40);
        chk_got("t_bp_o1", 1, 32'h80);
        chk_got("t_bp_o2", 2, 32'hC0);
        chk_got("t_bp_o3", 3, 32'h100);

        // ch_clear while a sample sits in stage 1: that sample's state write is dropped
        clear_y();
        got_q.delete();
        send(2'd0, 32'h100);
        ch_clear = 1;
        step();
        ch_clear = 0;
        send(2'd0, 32'h100);
        drain("t_chclr");
        chk_got("t_chclr_o0", 0, 32'h40);
        chk_got("t_chclr_o1", 1, 32'h40);

        // key_clear mid-load
        key_valid = 1;
        key_data  = exp_w[0];
        step();
        key_valid = 0;
        key_clear = 1;
        step();
        key_clear = 0;
        #1;
        chk("t_kclr_keyed", 64'(keyed), 64'd0);
        chk("t_kclr_in_ready", 64'(in_ready), 64'd1);
        clear_y();
        got_q.delete();
        send(2'd0, 32'h100);
        drain("t_kclr");
        chk_got("t_kclr_o0", 0, 32'h1D950CC4);

        // Reset mid-stream
        load_key(exp_w[0], exp_w[1]);
        clear_y();
        send(2'd0, 32'h100);
        send(2'd0, 32'h100);
        #2 rst = 0;
        #1 chk("t_rst_out_valid", 64'(out_valid), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        step();
        step();
        load_key(exp_w[0], exp_w[1]);
        got_q.delete();
        send(2'd0, 32'h100);
        drain("t_rst");
        chk_got("t_rst_o0", 0, 32'h40);

        // Randomized traffic with random keys and random back-pressure
        for (int r = 0; r < 3; r++) begin
            if (r == 0) load_key(exp_w[0], exp_w[1]);
            else load_key({$urandom, $urandom}, {$urandom, $urandom});
            clear_y();
            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_ch     = 2'($urandom_range(0, 3));
                in_data   = (c % 5 == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
                out_ready = ($urandom_range(0, 9) < 7);
                step();
            end
            drain("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/iir_filter_llki_mc.md
IIR_FILTER_LLKI_MC -- requirements
Module: iir_filter_llki_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent filter channels, 1..16.
REQ-002 SHALL have parameter DATA_W, default 32: sample width, signed two's complement; 64*KEY_WORDS SHALL be a multiple of DATA_W.
REQ-003 SHALL have parameter KEY_WORDS, default 2: number of 64-bit key words; KEY_W = 64*KEY_WORDS.
REQ-004 SHALL have parameter SHIFT, default 2: filter coefficient exponent, 1..DATA_W-1.
REQ-005 SHALL have parameter EXP_KEY, default 0: KEY_W-bit expected key.
REQ-006 clk  in  1  sole clock, all logic rising-edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 key_valid / key_ready / key_data  in / out / in  1/1/64  key-word load handshake.
REQ-009 key_clear  in  1  pulse: discard loaded key and return to UNKEYED.
REQ-010 ch_clear  in  1  pulse: zero all channel filter states.
REQ-011 in_valid / in_ready  in / out  1/1  sample input handshake.
REQ-012 in_ch / in_data  in  clog2(N_CH) / DATA_W  channel select and sample.
REQ-013 out_valid / out_ready  out / in  1/1  result handshake.
REQ-014 out_ch / out_data  out  clog2(N_CH) / DATA_W  channel tag and filtered sample.
REQ-015 keyed / key_match  out  1/1  FSM in KEYED; loaded key equals EXP_KEY.

Function
REQ-016 Key FSM states: UNKEYED, LOADING, KEYED.
REQ-017 UNKEYED/KEYED: key_ready=1; accepted word (key_valid&key_ready) writes word 0 (bits 63:0), word counter=1, go LOADING.
REQ-018 LOADING: key_ready=1; word k written to bits 64k+63:64k; after word KEY_WORDS-1 go KEYED, counter wraps to 0.
REQ-019 KEY_WORDS=1: first word goes straight to KEYED.
REQ-020 key_clear in any state: key register zeroed, counter=0, go UNKEYED; wins over a same-cycle key word.
REQ-021 in_ready = (state != LOADING) & pipeline-stage-1 can advance; samples accepted in UNKEYED are processed with zero actual key.
REQ-022 Stage 1 (on accept): register ch and masked = in_data ^ EXP_SLICE(ch) ^ ACT_SLICE(ch); slice(c) = key bits [(c mod (KEY_W/DATA_W))*DATA_W +: DATA_W].
REQ-023 Stage 2: d = masked - y[ch] at DATA_W+1 bits; y_new = y[ch] + (d >>> SHIFT) truncated to DATA_W (wraps); y[ch] <= y_new; out_data <= y_new.
REQ-024 Latency: accepted sample appears on out_valid exactly 2 cycles later when out_ready held high; full throughput 1 sample/cycle, same-channel back-to-back included (no hazard, state written at end of stage 2).
REQ-025 Back-pressure: out_valid held with stable out_ch/out_data until out_ready; both stages stall; in_ready falls same cycle stage 1 cannot drain.
REQ-026 ch_clear: all y[] zeroed at that edge; a sample in stage 2 that edge computes from old y but its state write is dropped; in-flight data not discarded.
REQ-027 key_match combinational from key register; keyed = (state==KEYED).

Reset
REQ-028 rst low: state UNKEYED, key register 0, counter 0, all y[] 0, both stages invalid.
REQ-029 Reset outputs: key_ready=1, in_ready=1, out_valid=0, out_ch=0, out_data=0, keyed=0, key_match=(EXP_KEY==0).
REQ-030 Reset mid-load or mid-stream discards partial key and in-flight samples; no output emitted for them.

Structure
REQ-031 Shared package iir_llki_pkg SHALL hold the key-FSM state enum, key word width (64), and slice-index function.
REQ-032 Key FSM and key register SHALL be sub-module llki_key_loader; filter pipeline and channel state in the top.

Verification
REQ-033 Defaults, EXP_KEY=0x0123456789ABCDEF_FEDCBA9876543210, load exact key, ch0 samples 0x100, 0x100 -> outputs 0x40 then 0x70, keyed=1, key_match=1.
REQ-034 Load key with word0 bit8 flipped, ch0 sample 0x100 -> output 0x0, key_match=0; ch1 sample 0x100 -> 0x40.
REQ-035 Interleaved ch0=0x100, ch1=0x200, ch0=0x100 back-to-back -> 0x40 (ch0), 0x80 (ch1), 0x70 (ch0), 1/cycle.
REQ-036 out_ready low 5 cycles during 4-sample stream -> out_data stable, in_ready low after 2 accepts, no loss or duplication.
REQ-037 key_clear during LOADING after word 0 -> state UNKEYED, key=0, in_ready returns 1 next cycle.
REQ-038 rst asserted mid-stream -> out_valid 0 immediately; after release ch0 sample 0x100 -> 0x40 (state zeroed).
